// File: rtl/fnn_pkg.sv
// fnn_pkg: shared types and constants for the fully connected layer blocks
package fnn_pkg;
  localparam int DATA_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/neuron_weight_sequencer.sv
// neuron_weight_sequencer: reads one weight per accepted activation and pairs them for the MAC
module neuron_weight_sequencer import fnn_pkg::*; #(
  parameter int numWeight = 10,
  parameter int addressWidth = numWeight > 1 ? $clog2(numWeight) : 1,
  parameter int dataWidth = DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    in_ready,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_rdata,
  output logic                    mac_valid,
  output logic [dataWidth-1:0]    mac_x,
  output logic [dataWidth-1:0]    mac_w,
  output logic                    mac_last,
  output logic                    busy,
  output logic                    done
);
  localparam logic [addressWidth-1:0] last_addr = addressWidth'(numWeight - 1);
  seq_state_t state, state_n;
  logic [addressWidth-1:0] cnt;
  logic [dataWidth-1:0] x_d;
  logic vld_d, last_d, accept, at_last;
  assign in_ready  = state == RUN;
  assign accept    = in_valid && in_ready;
  assign at_last   = cnt == last_addr;
  assign w_ren     = accept;
  assign w_radd    = cnt;
  assign mac_valid = vld_d;
  assign mac_x     = x_d;
  // the memory's one-cycle read latency matches the activation register, so the weight passes straight through
  assign mac_w     = w_rdata;
  assign mac_last  = last_d && vld_d;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN ? (accept && at_last ? DRAIN : RUN) :
              state == DRAIN ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      x_d    <= '0;
      vld_d  <= 1'b0;
      last_d <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) cnt <= '0;
      else if (accept && !at_last) cnt <= cnt + 1'b1;
      if (accept) x_d <= in_data;
      vld_d  <= accept;
      last_d <= accept && at_last;
    end
  end
endmodule

// File: doc/neuron_weight_sequencer.md
# neuron_weight_sequencer

Per-neuron read controller for the fully connected layers. It accepts a stream of input activations and issues one read to the neuron's weight memory for each accepted activation. It aligns each activation with the weight returned one cycle later and presents the pair to the neuron's MAC, flagging the last pair. It then signals completion to the layer controller. One instance sits between each neuron's weight memory (read port: ren/radd, 1-cycle registered read) and its MAC.

## Interface
Parameters:
- numWeight, 10, weights per neuron (= inputs per neuron); legal range ≥1
- addressWidth, $clog2(numWeight), weight address width; numWeight=1 uses width 1
- dataWidth, 16, activation and weight width (fixed-point, sign-agnostic here)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin one neuron pass; honoured only in IDLE
- in_valid  in  1  input activation valid
- in_data  in  dataWidth  input activation
- in_ready  out  1  sequencer accepts an activation this cycle
- w_ren  out  1  weight memory read enable
- w_radd  out  addressWidth  weight memory read address
- w_rdata  in  dataWidth  weight memory read data (valid the cycle after w_ren)
- mac_valid  out  1  mac_x/mac_w pair valid
- mac_x  out  dataWidth  aligned activation
- mac_w  out  dataWidth  aligned weight
- mac_last  out  1  qualifies the final pair of the pass
- busy  out  1  pass in progress (state ≠ IDLE)
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE (enum in package).
- IDLE: in_ready=0. start=1 → RUN, cnt←0.
- RUN: in_ready=1 (combinational, state==RUN). Accept = in_valid && in_ready.
  - On accept: w_ren=1, w_radd=cnt (combinational from cnt), x_d←in_data, vld_d←1.
  - If cnt==numWeight-1, last_d←1 and state→DRAIN. Otherwise cnt←cnt+1.
  - in_valid low: no read; cnt holds; vld_d←0.
- DRAIN: in_ready=0. Final pair is emitted; state→DONE.
- DONE: done=1 for exactly this cycle; state→IDLE.
- Output pair: mac_valid=vld_d, mac_x=x_d, mac_last=last_d&&vld_d (all registered). mac_w=w_rdata (pass-through, aligned by construction).
- start outside IDLE is ignored. in_valid outside RUN is not accepted.
- No downstream back-pressure: the MAC always consumes a pair.
- The address counter never wraps within a pass. It is cleared only by start and rst.

## Timing
- Throughput: one activation per cycle.
- Latency: accept at cycle T → mac_valid at T+1 with that activation's weight.
- Last accept at T: DRAIN and mac_last at T+1, done at T+2, busy=0 from T+3.
- Earliest restart: start at T+3 (IDLE) → RUN at T+4.
- Reset values: in_ready=0, w_ren=0, w_radd=0, mac_valid=0, mac_x=0, mac_last=0, busy=0, done=0, cnt=0, state=IDLE. mac_w follows memory.
- rst mid-pass: next cycle is IDLE with all of the above reset values. A pending mac_valid is dropped and no done is issued.
- rst and start in the same cycle: rst wins.
- numWeight=1: first accept goes RUN→DRAIN directly, with mac_last on the only pair.

## Structure
- Shared package fnn_pkg: state enum typedef (seq_state_t), default dataWidth constant.
- No sub-module. Counter, FSM and alignment registers live in a single always_ff plus combinational outputs.
- Layer controller fans start out to all neurons of a layer and ANDs their done signals.

## Test plan
- Reset, then start, then 10 back-to-back activations 1..10 against the layer-4 neuron-2 weight ROM → 10 mac_valid cycles. Pair 0 = (1, 16'hF3F0), pair 1 = (2, 16'hA60B), pair 9 = (10, 16'h0BE4) with mac_last=1. done exactly 2 cycles after the last accept.
- Same pass with in_valid low for 3 cycles after the 4th activation → w_radd holds at 4, no mac_valid during the gap, pair order and weights unchanged.
- start pulsed while busy, and in_valid driven in IDLE/DRAIN/DONE → ignored. in_ready=0, no w_ren, cnt unaffected.
- rst asserted after the 6th accept → next cycle IDLE, all outputs 0, no done. A new start gives a full 10-pair pass beginning at address 0.
- Two consecutive passes with start at the first IDLE cycle after done → second pass restarts at address 0, identical pairs.
- numWeight=1 build → single pair with mac_last=1, done 2 cycles after the accept.
